// File: rtl/m68k_bus_ctrl_if.sv
// CPU-side 68000 bus signals seen by the bus controller: strobes, address page,
// the external device-ready trigger, and the decoded chip selects.
interface m68k_bus_if #(
  parameter int unsigned NREG = 4
);
  logic            as_n;
  logic            uds_n;
  logic            lds_n;
  logic            rw;
  logic [10:0]     addr;
  logic            dtack_trig;
  logic [NREG-1:0] cs;

  modport master (output as_n, uds_n, lds_n, rw, addr, dtack_trig, input cs);
  modport slave  (input as_n, uds_n, lds_n, rw, addr, dtack_trig, output cs);
endinterface

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: page decode with boot-ROM overlay, per-region DTACK
// timing (wait count or external trigger), and BERR on unmapped or stalled cycles.
module m68k_bus_ctrl #(
  parameter int unsigned          NREG      = 4,
  // Region tables list region 0 first (leftmost); REG_EXT uses bit i for region i.
  parameter logic [NREG*11-1:0]   REG_BASE  = {11'h000, 11'h080, 11'h082, 11'h088},
  parameter logic [NREG*11-1:0]   REG_PAGES = {11'h080, 11'h002, 11'h006, 11'h008},
  parameter logic [NREG*4-1:0]    REG_WAIT  = {4'd0, 4'd4, 4'd2, 4'd0},
  parameter logic [NREG-1:0]      REG_EXT   = 4'b1000,
  parameter int unsigned          OVL_REG   = 1,
  parameter logic [10:0]          OVL_PAGES = 11'h002,
  parameter int unsigned          TIMEOUT   = 64
) (
  input  logic       clk16,
  input  logic       reset_n,
  m68k_bus_if.slave  bus,
  inout  wire        dtack_n,
  inout  wire        berr_n,
  output logic       overlay_active,
  output logic [7:0] timeout_cnt
);

  localparam int unsigned WD_W     = 8;
  localparam int unsigned WCNT_W   = 4;
  localparam logic [WD_W-1:0] TMO_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EXTW,
    S_ACK,
    S_BERR
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [7:0]          tcnt_q, tcnt_d;
  logic                ovl_q, ovl_d;
  logic                dtack_q, dtack_d;
  logic                berr_q, berr_d;
  logic [2:0]          sync_q;

  logic [NREG-1:0]     cs_c;
  logic                hit_c;
  logic [WCNT_W-1:0]   wait_c;
  logic                ext_c;
  logic                ovl_hit_c;
  logic                strobe_c;
  logic                trig_edge_c;
  logic                count_c;
  logic                tmo_c;

  function automatic logic in_region(input int unsigned idx, input logic [10:0] a);
    logic [11:0] lo;
    logic [11:0] hi;
    lo = {1'b0, REG_BASE[(NREG-1-idx)*11 +: 11]};
    hi = lo + {1'b0, REG_PAGES[(NREG-1-idx)*11 +: 11]};
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  function automatic logic [WCNT_W-1:0] reg_wait(input int unsigned idx);
    return REG_WAIT[(NREG-1-idx)*4 +: 4];
  endfunction

  // Address decode: overlay reads of the low pages win, else lowest matching region.
  always_comb begin
    cs_c      = '0;
    hit_c     = 1'b0;
    wait_c    = '0;
    ext_c     = 1'b0;
    ovl_hit_c = ovl_q && bus.rw && (bus.addr < OVL_PAGES);
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!hit_c && (ovl_hit_c ? (i == OVL_REG) : in_region(i, bus.addr))) begin
        hit_c   = 1'b1;
        cs_c[i] = 1'b1;
        wait_c  = reg_wait(i);
        ext_c   = REG_EXT[i];
      end
    end
    if (bus.as_n) begin
      cs_c  = '0;
      hit_c = 1'b0;
    end
  end

  assign bus.cs      = cs_c;
  assign strobe_c    = ~(bus.uds_n & bus.lds_n);
  assign trig_edge_c = sync_q[1] & ~sync_q[2];

  // Next-state and watchdog logic.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    ovl_d   = ovl_q;
    count_c = 1'b0;
    tmo_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!bus.as_n && strobe_c) begin
          if (!hit_c) begin
            state_d = S_BERR;
          end else if (ext_c) begin
            state_d = S_EXTW;
            count_c = 1'b1;
          end else if (wait_c == '0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = wait_c - WCNT_W'(1);
            count_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        count_c = 1'b1;
        if (wcnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
          if (wd_q == TMO_LAST) begin
            state_d = S_BERR;
            tmo_c   = 1'b1;
          end
        end
      end
      S_EXTW: begin
        count_c = 1'b1;
        if (trig_edge_c) begin
          state_d = S_ACK;
        end else if (wd_q == TMO_LAST) begin
          state_d = S_BERR;
          tmo_c   = 1'b1;
        end
      end
      S_ACK: begin
        if (!strobe_c) state_d = S_IDLE;
      end
      S_BERR: begin
        state_d = S_BERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The accepting edge is counted so BERR lands TIMEOUT cycles after the strobe.
    if (bus.as_n) begin
      state_d = S_IDLE;
      wd_d    = '0;
    end else begin
      if (count_c) wd_d = wd_q + WD_W'(1);
      if (tmo_c && (tcnt_q != 8'hFF)) tcnt_d = tcnt_q + 8'd1;
      if (!bus.rw && (bus.addr < OVL_PAGES)) ovl_d = 1'b0;
    end

    dtack_d = (state_d == S_ACK) && strobe_c;
    berr_d  = (state_d == S_BERR);
  end

  always_ff @(posedge clk16 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      wd_q    <= '0;
      tcnt_q  <= '0;
      ovl_q   <= 1'b1;
      dtack_q <= 1'b0;
      berr_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
      ovl_q   <= ovl_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
      sync_q  <= {sync_q[1:0], bus.dtack_trig};
    end
  end

  // Open-drain style strobes: pulled low or released.
  assign dtack_n        = dtack_q ? 1'b0 : 1'bz;
  assign berr_n         = berr_q  ? 1'b0 : 1'bz;
  assign overlay_active = ovl_q;
  assign timeout_cnt    = tcnt_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Bench for m68k_bus_ctrl: directed and random bus cycles checked against a
// table-driven model of decode, DTACK/BERR latency, overlay and watchdog counts.
module tb_m68k_bus_ctrl;
  localparam int unsigned TMO = 64;

  logic       clk16   = 1'b0;
  logic       reset_n = 1'b1;
  wire        dtack_n;
  wire        berr_n;
  logic       overlay_active;
  logic [7:0] timeout_cnt;

  m68k_bus_if #(.NREG(4)) bus ();

  pullup (dtack_n);
  pullup (berr_n);

  m68k_bus_ctrl dut (
    .clk16          (clk16),
    .reset_n        (reset_n),
    .bus            (bus),
    .dtack_n        (dtack_n),
    .berr_n         (berr_n),
    .overlay_active (overlay_active),
    .timeout_cnt    (timeout_cnt)
  );

  always #5 clk16 = ~clk16;

  int unsigned m_base  [4] = '{32'h000, 32'h080, 32'h082, 32'h088};
  int unsigned m_pages [4] = '{32'h080, 32'h002, 32'h006, 32'h008};
  int          m_wait  [4] = '{0, 4, 2, 0};
  bit          m_ext   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [10:0] pool    [12] = '{11'h000, 11'h001, 11'h002, 11'h07F, 11'h080, 11'h081,
                                11'h082, 11'h087, 11'h088, 11'h08F, 11'h090, 11'h100};
  bit          m_ovl  = 1'b1;
  int          m_tcnt = 0;
  int          tests  = 0;
  int          fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Region selected by the model, -1 when unmapped.
  function automatic int m_region(input int unsigned a, input bit rd);
    if (m_ovl && rd && a < 2) return 1;
    for (int i = 0; i < 4; i++)
      if (a >= m_base[i] && a < m_base[i] + m_pages[i]) return i;
    return -1;
  endfunction

  task automatic bus_cycle(input logic [10:0] a, input bit rd, input bit u, input bit l,
                           input int trig_at, input string tag);
    int reg_i;
    int exp_lat;
    bit exp_berr;
    int lat;
    bit got_berr;
    bit clash;
    lat      = 0;
    got_berr = 1'b0;
    clash    = 1'b0;
    reg_i    = m_region(32'(a), rd);
    if (reg_i < 0) begin
      exp_lat  = 1;
      exp_berr = 1'b1;
    end else if (m_ext[reg_i]) begin
      if (trig_at > 0 && trig_at + 3 <= int'(TMO)) begin
        exp_lat  = trig_at + 3;
        exp_berr = 1'b0;
      end else begin
        exp_lat  = int'(TMO);
        exp_berr = 1'b1;
        if (m_tcnt < 255) m_tcnt++;
      end
    end else begin
      exp_lat  = m_wait[reg_i] + 1;
      exp_berr = 1'b0;
    end

    @(negedge clk16);
    bus.addr  = a;
    bus.rw    = rd;
    bus.uds_n = u;
    bus.lds_n = l;
    bus.as_n  = 1'b0;
    #1;
    check({tag, " cs"}, 32'(bus.cs), (reg_i < 0) ? 32'd0 : (32'd1 << reg_i));
    if (!rd && a < 11'd2) m_ovl = 1'b0;

    for (int c = 1; c <= int'(TMO) + 8 && lat == 0; c++) begin
      @(negedge clk16);
      bus.dtack_trig = (c == trig_at);
      if (dtack_n === 1'b0 && berr_n === 1'b0) clash = 1'b1;
      if (dtack_n === 1'b0 || berr_n === 1'b0) begin
        lat      = c;
        got_berr = (berr_n === 1'b0);
      end
    end
    bus.dtack_trig = 1'b0;

    check({tag, " latency"},   32'(lat),            32'(exp_lat));
    check({tag, " berr"},      32'(got_berr),       32'(exp_berr));
    check({tag, " exclusive"}, 32'(clash),          32'd0);
    check({tag, " overlay"},   32'(overlay_active), 32'(m_ovl));
    check({tag, " tcnt"},      32'(timeout_cnt),    32'(m_tcnt));

    @(negedge clk16);
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b1;
    @(negedge clk16);
    check({tag, " dtack off"}, 32'(dtack_n), 32'd1);
    check({tag, " berr hold"}, 32'(berr_n),  exp_berr ? 32'd0 : 32'd1);
    bus.as_n = 1'b1;
    #1;
    check({tag, " cs idle"}, 32'(bus.cs), 32'd0);
    @(negedge clk16);
    check({tag, " released"}, 32'({dtack_n, berr_n}), 32'd3);
  endtask

  task automatic start(input logic [10:0] a, input bit rd, input int cycles);
    @(negedge clk16);
    bus.addr  = a;
    bus.rw    = rd;
    bus.uds_n = 1'b0;
    bus.lds_n = 1'b0;
    bus.as_n  = 1'b0;
    repeat (cycles) @(negedge clk16);
  endtask

  task automatic reset_mid(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check({tag, " dtack"},   32'(dtack_n),        32'd1);
    check({tag, " berr"},    32'(berr_n),         32'd1);
    check({tag, " overlay"}, 32'(overlay_active), 32'd1);
    check({tag, " tcnt"},    32'(timeout_cnt),    32'd0);
    m_ovl  = 1'b1;
    m_tcnt = 0;
    bus.as_n  = 1'b1;
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b1;
    @(negedge clk16);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.as_n       = 1'b1;
    bus.uds_n      = 1'b1;
    bus.lds_n      = 1'b1;
    bus.rw         = 1'b1;
    bus.addr       = '0;
    bus.dtack_trig = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst dtack",   32'(dtack_n),        32'd1);
    check("rst berr",    32'(berr_n),         32'd1);
    check("rst overlay", 32'(overlay_active), 32'd1);
    check("rst tcnt",    32'(timeout_cnt),    32'd0);
    check("rst cs",      32'(bus.cs),         32'd0);
    repeat (3) @(negedge clk16);
    reset_n = 1'b1;

    bus_cycle(11'h000, 1'b1, 1'b0, 1'b1, 0,  "ovl_rd");
    bus_cycle(11'h001, 1'b0, 1'b0, 1'b0, 0,  "ovl_wr");
    bus_cycle(11'h000, 1'b1, 1'b0, 1'b0, 0,  "ram_rd");
    bus_cycle(11'h084, 1'b1, 1'b1, 1'b0, 0,  "wait2");
    bus_cycle(11'h088, 1'b1, 1'b0, 1'b0, 10, "ext_trig");
    bus_cycle(11'h088, 1'b1, 1'b0, 1'b0, 0,  "ext_tmo");
    bus_cycle(11'h100, 1'b1, 1'b0, 1'b0, 0,  "unmapped");
    bus_cycle(11'h088, 1'b1, 1'b0, 1'b0, 61, "ext_race");
    bus_cycle(11'h08F, 1'b1, 1'b0, 1'b0, 62, "ext_late");
    bus_cycle(11'h07F, 1'b0, 1'b0, 1'b0, 0,  "ram_top");
    bus_cycle(11'h081, 1'b1, 1'b0, 1'b0, 3,  "rom_top");
    bus_cycle(11'h087, 1'b1, 1'b0, 1'b1, 0,  "io_top");
    bus_cycle(11'h090, 1'b1, 1'b0, 1'b0, 0,  "gap");

    start(11'h000, 1'b1, 2);
    check("ack held", 32'(dtack_n), 32'd0);
    reset_mid("rst_ack");
    start(11'h080, 1'b1, 2);
    check("wait pending", 32'(dtack_n), 32'd1);
    reset_mid("rst_wait");
    start(11'h100, 1'b1, 2);
    check("berr held", 32'(berr_n), 32'd0);
    reset_mid("rst_berr");

    for (int n = 0; n < 60; n++) begin
      logic [10:0] a;
      int          s;
      a = ($urandom_range(0, 3) == 0) ? 11'($urandom) : pool[$urandom_range(0, 11)];
      s = int'($urandom_range(0, 2));
      bus_cycle(a, 1'($urandom_range(0, 1)), (s == 1), (s == 2),
                int'($urandom_range(0, 66)), "rand");
    end

    while (m_tcnt < 255) bus_cycle(11'h088, 1'b1, 1'b0, 1'b0, 0, "sat");
    bus_cycle(11'h08A, 1'b1, 1'b0, 1'b0, 0, "sat_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
